// File: rtl/array_frame_pkg.sv
// array_frame_pkg: shared state type, default geometry and word addressing for the frame serializer
package array_frame_pkg;
    typedef enum logic {IDLE, STREAM} state_t;
    localparam int DEF_ROWS  = 16;
    localparam int DEF_COLS  = 9;
    localparam int DEF_WIDTH = 32;
    function automatic int word_lsb(input int r, input int c, input int cols = DEF_COLS, input int width = DEF_WIDTH);
        return (r * cols + c) * width;
    endfunction
endpackage

// File: rtl/array_frame_buf.sv
// array_frame_buf: capture-enabled frame register with a (row,col) word read mux
module array_frame_buf
    import array_frame_pkg::*;
#(
    parameter  int ROWS  = DEF_ROWS,
    parameter  int COLS  = DEF_COLS,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int RW    = $clog2(ROWS),
    localparam int CW    = $clog2(COLS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_capture,
    input  logic [ROWS*COLS*WIDTH-1:0]  i_frame_data,
    input  logic [RW-1:0]               i_row,
    input  logic [CW-1:0]               i_col,
    output logic [WIDTH-1:0]            o_word_data
);
    logic [ROWS*COLS*WIDTH-1:0] r_buf;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_buf <= '0;
        else if (i_capture)
            r_buf <= i_frame_data;

    assign o_word_data = r_buf[word_lsb(int'(i_row), int'(i_col), COLS, WIDTH) +: WIDTH];
endmodule

// File: rtl/array_frame_serializer.sv
// array_frame_serializer: captures a whole flat frame in one handshake and streams it word by word in row-major order
module array_frame_serializer
    import array_frame_pkg::*;
#(
    parameter  int ROWS  = DEF_ROWS,
    parameter  int COLS  = DEF_COLS,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int RW    = $clog2(ROWS),
    localparam int CW    = $clog2(COLS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_flush,
    input  logic                        i_frame_valid,
    output logic                        o_frame_ready,
    input  logic [ROWS*COLS*WIDTH-1:0]  i_frame_data,
    output logic                        o_word_valid,
    input  logic                        i_word_ready,
    output logic [WIDTH-1:0]            o_word_data,
    output logic [RW-1:0]               o_row,
    output logic [CW-1:0]               o_col,
    output logic                        o_row_last,
    output logic                        o_frame_last,
    output logic                        o_busy
);
    state_t        r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_busy, w_col_last, w_last, w_beat, w_capture;

    assign w_busy     = r_state == STREAM;
    assign w_col_last = r_col == CW'(COLS - 1);
    assign w_last     = w_col_last && r_row == RW'(ROWS - 1);
    assign w_beat     = w_busy && i_word_ready;
    // A new frame may land on the same edge as the final beat so frames stream without a bubble
    assign o_frame_ready = !i_flush && (!w_busy || (w_beat && w_last));
    assign w_capture     = i_frame_valid && o_frame_ready;

    assign o_word_valid = w_busy;
    assign o_busy       = w_busy;
    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_row_last   = w_col_last;
    assign o_frame_last = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else if (i_flush) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else if (w_capture) begin
            r_state <= STREAM;
            r_row   <= '0;
            r_col   <= '0;
        end else if (w_beat) begin
            r_state <= w_last ? IDLE : STREAM;
            r_col   <= w_col_last ? '0 : r_col + 1'b1;
            r_row   <= w_last ? '0 : w_col_last ? r_row + 1'b1 : r_row;
        end

    array_frame_buf #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_buf (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_capture    (w_capture),
        .i_frame_data (i_frame_data),
        .i_row        (r_row),
        .i_col        (r_col),
        .o_word_data  (o_word_data)
    );
endmodule

// File: tb/tb_array_frame_serializer.sv
// tb_array_frame_serializer: randomized frames checked against a row-major word-sequence model
module tb_array_frame_serializer;
    localparam int ROWS = 16, COLS = 9, W = 32, FW = ROWS * COLS * W;
    localparam int R2 = 2, C2 = 3, FW2 = R2 * C2 * W;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, fvalid = 1'b0, wready = 1'b0;
    logic [FW-1:0] fdata = '0;
    logic fready, wvalid, rlast, flast, busy;
    logic [W-1:0] wdata;
    logic [3:0] row, col;

    logic fvalid2 = 1'b0, wready2 = 1'b0;
    logic [FW2-1:0] fdata2 = '0;
    logic fready2, wvalid2, rlast2, flast2, busy2;
    logic [W-1:0] wdata2;
    logic [0:0] row2;
    logic [1:0] col2;

    typedef struct {int r; int c; logic [W-1:0] d;} beat_t;
    beat_t exp_q[$];
    logic [FW-1:0] pend[$];
    int vectors = 0, miscompares = 0, cyc;

    always #5 clk = ~clk;

    array_frame_serializer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_frame_valid(fvalid), .o_frame_ready(fready),
        .i_frame_data(fdata), .o_word_valid(wvalid), .i_word_ready(wready), .o_word_data(wdata),
        .o_row(row), .o_col(col), .o_row_last(rlast), .o_frame_last(flast), .o_busy(busy)
    );

    array_frame_serializer #(.ROWS(R2), .COLS(C2), .WIDTH(W)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_frame_valid(fvalid2), .o_frame_ready(fready2),
        .i_frame_data(fdata2), .o_word_valid(wvalid2), .i_word_ready(wready2), .o_word_data(wdata2),
        .o_row(row2), .o_col(col2), .o_row_last(rlast2), .o_frame_last(flast2), .o_busy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] make_frame(input bit pattern);
        logic [FW-1:0] f;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                f[(r * COLS + c) * W +: W] = pattern ? W'((r << 8) | c) : $urandom;
        return f;
    endfunction

    task automatic push_exp(input logic [FW-1:0] f);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back('{r, c, f[(r * COLS + c) * W +: W]});
    endtask

    task automatic check_head();
        beat_t h;
        if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(exp_q.size()), 64'd1);
        end else begin
            h = exp_q[0];
            chk("row", row, h.r);
            chk("col", col, h.c);
            chk("data", wdata, h.d);
            chk("row_last", rlast, h.c == COLS - 1);
            chk("frame_last", flast, h.r == ROWS - 1 && h.c == COLS - 1);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_fready"}, fready, 1);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_rlast"}, rlast, 0);
        chk({tag, "_flast"}, flast, 0);
        chk({tag, "_data"}, wdata, 0);
    endtask

    // Drives pending frames and word-ready until the model drains, stop_at beats pass, or the budget expires
    task automatic run(input int ready_pct, input int stop_at, input int max_cycles, output int cycles);
        int beats = 0;
        bit acc, facc;
        cycles = 0;
        while ((exp_q.size() > 0 || pend.size() > 0) && beats != stop_at && cycles < max_cycles) begin
            @(negedge clk);
            if (wvalid) check_head();
            wready = ($urandom_range(99) < ready_pct);
            fvalid = pend.size() > 0;
            if (fvalid) fdata = pend[0];
            #1;
            acc  = wvalid && wready;
            facc = fvalid && fready;
            @(posedge clk);
            cycles++;
            if (acc) begin
                void'(exp_q.pop_front());
                beats++;
            end
            if (facc) push_exp(pend.pop_front());
        end
        chk("budget", cycles < max_cycles, 1);
        #1 fvalid = 1'b0;
    endtask

    initial begin
        #1 check_reset("rst");
        @(negedge clk) rst_n = 1'b1;
        #1 check_reset("idle");

        pend.push_back(make_frame(1'b1));
        run(100, -1, 400, cyc);
        chk("full_cycles", cyc, 145);
        @(negedge clk);
        chk("after_fready", fready, 1);
        chk("after_wvalid", wvalid, 0);

        pend.push_back(make_frame(1'b0));
        run(50, -1, 3000, cyc);
        @(negedge clk);
        chk("rand_done_wvalid", wvalid, 0);

        pend.push_back(make_frame(1'b0));
        pend.push_back(make_frame(1'b0));
        run(100, -1, 700, cyc);
        chk("b2b_cycles", cyc, 289);

        pend.push_back(make_frame(1'b0));
        run(100, 40, 400, cyc);
        @(negedge clk);
        check_head();
        flush = 1'b1;
        wready = 1'b1;
        #1 chk("flush_fready", fready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_wvalid", wvalid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_row", row, 0);
        chk("flush_col", col, 0);
        chk("flush_fready_after", fready, 1);

        @(negedge clk);
        flush = 1'b1;
        fvalid = 1'b1;
        fdata = make_frame(1'b0);
        #1 chk("flush_offer_fready", fready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        fvalid = 1'b0;
        @(negedge clk);
        chk("flush_offer_busy", busy, 0);

        pend.push_back(make_frame(1'b0));
        run(100, 70, 400, cyc);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst");
        exp_q.delete();
        pend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pend.push_back(make_frame(1'b0));
        run(60, -1, 3000, cyc);

        @(negedge clk);
        for (int i = 0; i < R2 * C2; i++) fdata2[i * W +: W] = $urandom;
        fvalid2 = 1'b1;
        #1 chk("small_fready", fready2, 1);
        @(posedge clk);
        #1 fvalid2 = 1'b0;
        wready2 = 1'b1;
        for (int i = 0; i < R2 * C2; i++) begin
            @(negedge clk);
            chk("small_valid", wvalid2, 1);
            chk("small_row", row2, i / C2);
            chk("small_col", col2, i % C2);
            chk("small_data", wdata2, fdata2[i * W +: W]);
            chk("small_rlast", rlast2, (i % C2) == C2 - 1);
            chk("small_flast", flast2, i == R2 * C2 - 1);
        end
        @(negedge clk);
        chk("small_end_valid", wvalid2, 0);
        chk("small_end_busy", busy2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
